// File: rtl/lfsr_prng_gen.sv
// Parametrised Fibonacci-LFSR random word generator with seed load, multi-step requests and valid/ready output.
// Optional build macro PRNG_LEAP_EN: advance two LFSR steps per clock while two or more remain.
module lfsr_prng_gen #(
    parameter int unsigned       WIDTH        = 32,
    parameter logic [WIDTH-1:0]  TAPS         = WIDTH'(32'h8020_0003),
    parameter logic [WIDTH-1:0]  DEFAULT_SEED = WIDTH'(32'h0000_0001),
    parameter int unsigned       STEP_W       = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              seed_load,
    input  logic [WIDTH-1:0]  seed,
    input  logic              req,
    input  logic [STEP_W-1:0] n_steps,
    output logic              busy,
    output logic [WIDTH-1:0]  q,
    output logic              q_valid,
    input  logic              q_ready,
    output logic              lockup
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]        fsm_q,    fsm_d;
    logic [WIDTH-1:0]  lfsr_q,   lfsr_d;
    logic [STEP_W-1:0] cnt_q,    cnt_d;
    logic              busy_q,   busy_d;
    logic              valid_q,  valid_d;
    logic              lockup_q, lockup_d;

    logic [WIDTH-1:0]  step1;
    logic [WIDTH-1:0]  step2;
    logic [STEP_W-1:0] n_eff;
    logic              seed_zero;

    // One Fibonacci shift: new LSB is the parity of the tapped bits.
    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
        return {s[WIDTH-2:0], ^(s & TAPS)};
    endfunction

    assign step1     = lfsr_step(lfsr_q);
    assign step2     = lfsr_step(step1);
    assign n_eff     = (n_steps == '0) ? STEP_W'(1) : n_steps;
    assign seed_zero = (seed == '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fsm_q    <= S_IDLE;
            lfsr_q   <= DEFAULT_SEED;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            lockup_q <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            lfsr_q   <= lfsr_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            lockup_q <= lockup_d;
        end
    end

    // Seed load overrides everything; otherwise IDLE -> RUN -> HOLD -> IDLE.
    always_comb begin
        fsm_d    = fsm_q;
        lfsr_d   = lfsr_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        valid_d  = valid_q;
        lockup_d = 1'b0;

        if (seed_load) begin
            fsm_d    = S_IDLE;
            lfsr_d   = seed_zero ? DEFAULT_SEED : seed;
            lockup_d = seed_zero;
            cnt_d    = '0;
            busy_d   = 1'b0;
            valid_d  = 1'b0;
        end else begin
            case (fsm_q)
                S_IDLE: begin
                    if (req) begin
                        cnt_d  = n_eff;
                        fsm_d  = S_RUN;
                        busy_d = 1'b1;
                    end
                end
                S_RUN: begin
`ifdef PRNG_LEAP_EN
                    if (cnt_q > STEP_W'(1)) begin
                        lfsr_d = step2;
                        cnt_d  = cnt_q - STEP_W'(2);
                    end else begin
                        lfsr_d = step1;
                        cnt_d  = cnt_q - STEP_W'(1);
                    end
`else
                    lfsr_d = step1;
                    cnt_d  = cnt_q - STEP_W'(1);
`endif
                    if (cnt_d == '0) begin
                        fsm_d   = S_HOLD;
                        valid_d = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (q_ready) begin
                        fsm_d   = S_IDLE;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                    end
                end
                default: begin
                    fsm_d   = S_IDLE;
                    busy_d  = 1'b0;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    assign q       = lfsr_q;
    assign busy    = busy_q;
    assign q_valid = valid_q;
    assign lockup  = lockup_q;

endmodule

// File: tb/tb_lfsr_prng_gen.sv
// Scoreboard bench for lfsr_prng_gen: random seeds/step counts against an arithmetic LFSR model.
module tb_lfsr_prng_gen;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned STEP_W = 8;
    localparam logic [31:0] TAPS   = 32'h8020_0003;

    logic              clk = 1'b0;
    logic              rstn;
    logic              seed_load;
    logic [WIDTH-1:0]  seed;
    logic              req;
    logic [STEP_W-1:0] n_steps;
    logic              busy;
    logic [WIDTH-1:0]  q;
    logic              q_valid;
    logic              q_ready;
    logic              lockup;

    int     n_tests = 0;
    int     n_fail  = 0;
    longint cyc     = 0;

    typedef struct {
        logic [31:0] q;
        longint      accept;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mstate;

    lfsr_prng_gen dut (
        .clk       (clk),
        .rstn      (rstn),
        .seed_load (seed_load),
        .seed      (seed),
        .req       (req),
        .n_steps   (n_steps),
        .busy      (busy),
        .q         (q),
        .q_valid   (q_valid),
        .q_ready   (q_ready),
        .lockup    (lockup)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Model: shift left, new LSB = parity of the tapped bits.
    function automatic logic [31:0] m_shift(input logic [31:0] s);
        return (s << 1) | 32'($countones(s & TAPS) % 2);
    endfunction

    function automatic logic [31:0] m_adv(input logic [31:0] s, input int n);
        logic [31:0] r;
        int k;
        r = s;
        k = (n == 0) ? 1 : n;
        for (int i = 0; i < k; i++) r = m_shift(r);
        return r;
    endfunction

    function automatic int m_lat(input int n);
        int k;
        k = (n == 0) ? 1 : n;
`ifdef PRNG_LEAP_EN
        return (k + 1) / 2;
`else
        return k;
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: each rising q_valid must match the oldest outstanding request.
    initial begin
        exp_t e;
        logic prev_v;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                prev_v = 1'b0;
            end else begin
                if (q_valid && !prev_v) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_valid", 64'(q_valid), 64'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("sb_q", 64'(q), 64'(e.q));
                        chk("sb_latency", 64'(cyc - e.accept), 64'(e.lat));
                    end
                end
                prev_v = q_valid;
            end
        end
    end

    task automatic do_load(input logic [31:0] s, input bit with_req);
        seed_load = 1'b1;
        seed      = s;
        req       = with_req;
        n_steps   = STEP_W'($urandom_range(0, 255));
        @(negedge clk);
        seed_load = 1'b0;
        req       = 1'b0;
        mstate    = (s == 32'd0) ? 32'd1 : s;
        chk("load_q", 64'(q), 64'(mstate));
        chk("load_lockup", 64'(lockup), 64'(s == 32'd0));
        chk("load_busy", 64'(busy), 64'd0);
        chk("load_valid", 64'(q_valid), 64'd0);
        @(negedge clk);
        chk("lockup_end", 64'(lockup), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
    endtask

    task automatic do_req(input int n, input int hold_cyc, input bit req_on_ready);
        logic [31:0] held;
        exp_t e;
        bit got;
        req     = 1'b1;
        n_steps = STEP_W'(n);
        mstate  = m_adv(mstate, n);
        e.q      = mstate;
        e.accept = cyc + 1;
        e.lat    = m_lat(n);
        sb.push_back(e);
        @(negedge clk);
        req = 1'b0;
        chk("busy_after_accept", 64'(busy), 64'd1);
        got = 1'b0;
        for (int k = 0; k < m_lat(n) + 4 && !got; k++) begin
            if (q_valid) begin
                got     = 1'b1;
                q_ready = 1'b0;
            end else begin
                q_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
        end
        q_ready = 1'b0;
        if (!got) begin
            chk("valid_timeout", 64'd0, 64'd1);
            sb.delete();
            return;
        end
        chk("result_q", 64'(q), 64'(mstate));
        held = q;
        for (int i = 0; i < hold_cyc; i++) begin
            req     = 1'($urandom_range(0, 1));
            n_steps = STEP_W'($urandom_range(0, 255));
            @(negedge clk);
            chk("hold_q", 64'(q), 64'(held));
            chk("hold_valid", 64'(q_valid), 64'd1);
            chk("hold_busy", 64'(busy), 64'd1);
        end
        req     = req_on_ready;
        q_ready = 1'b1;
        @(negedge clk);
        req     = 1'b0;
        q_ready = 1'b0;
        chk("release_valid", 64'(q_valid), 64'd0);
        chk("release_busy", 64'(busy), 64'd0);
        chk("release_q", 64'(q), 64'(held));
    endtask

    // Start a long request, then seed-load over it; no result may ever appear.
    task automatic do_abort(input int n, input int k, input logic [31:0] s);
        bit seen;
        req     = 1'b1;
        n_steps = STEP_W'(n);
        @(negedge clk);
        req = 1'b0;
        repeat (k) @(negedge clk);
        do_load(s, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < m_lat(n) + 4; i++) begin
            @(negedge clk);
            if (q_valid || busy) seen = 1'b1;
        end
        chk("abort_no_result", 64'(seen), 64'd0);
        chk("abort_q", 64'(q), 64'(mstate));
    endtask

    initial begin
        int n;
        rstn      = 1'b0;
        seed_load = 1'b0;
        seed      = '0;
        req       = 1'b0;
        n_steps   = '0;
        q_ready   = 1'b0;
        #12;
        chk("reset_q", 64'(q), 64'h1);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_valid", 64'(q_valid), 64'd0);
        chk("reset_lockup", 64'(lockup), 64'd0);
        @(negedge clk);
        rstn   = 1'b1;
        mstate = 32'd1;
        @(negedge clk);

        do_load(32'h1, 1'b0);
        do_req(3, 0, 1'b0);
        chk("vec_n3", 64'(q), 64'hD);
        do_load(32'h1, 1'b0);
        do_req(0, 0, 1'b0);
        chk("vec_n0", 64'(q), 64'h3);
        do_load(32'h1, 1'b0);
        do_req(4, 5, 1'b1);
        do_load(32'h0, 1'b0);
        chk("zero_seed_q", 64'(q), 64'h1);
        do_abort(200, 3, 32'h1234_5678);

        // Reset mid-run with no clock edge in between.
        req     = 1'b1;
        n_steps = STEP_W'(50);
        @(negedge clk);
        req = 1'b0;
        repeat (5) @(negedge clk);
        @(posedge clk);
        #3 rstn = 1'b0;
        #1;
        chk("midrun_reset_q", 64'(q), 64'h1);
        chk("midrun_reset_busy", 64'(busy), 64'd0);
        chk("midrun_reset_valid", 64'(q_valid), 64'd0);
        @(negedge clk);
        rstn   = 1'b1;
        mstate = 32'd1;
        @(negedge clk);

        // Reset while the lockup pulse is high clears it at once.
        seed_load = 1'b1;
        seed      = '0;
        @(negedge clk);
        seed_load = 1'b0;
        chk("lockup_high", 64'(lockup), 64'd1);
        #2 rstn = 1'b0;
        #1;
        chk("reset_clears_lockup", 64'(lockup), 64'd0);
        @(negedge clk);
        rstn   = 1'b1;
        mstate = 32'd1;
        @(negedge clk);

        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 3) == 0)
                do_load(($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 9) == 0)
                do_abort($urandom_range(4, 60), $urandom_range(0, 2), 32'($urandom));
            n = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 12);
            do_req(n, $urandom_range(0, 5), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
